// File: rtl/dmem_store_buffer_unit.sv
// dmem_store_buffer_unit
// Data memory behind the MEM stage. Stores are posted into a FIFO store
// buffer that drains into a single-write-port word array. Loads are
// combinational: the array word is overlaid with every matching buffered
// store (oldest to youngest), then the addressed byte/half/word is
// left-aligned. A debug port shares the array write port with the drain.
//
// Ports (big-endian bit numbering, bit 0 = MSB):
//   clk, rst        clock, asynchronous active-high reset
//   MemWrite        store request this cycle
//   dmem_addr       byte address; offset [30:31], word index [30-ADDR_W:29]
//   byte_select     00 byte, 01 half, 10/11 word
//   dmem_din        right-aligned store data
//   dmem_dout       left-aligned load data (zero filled)
//   dbg_req/addr/wdata  debug whole-word write request
//   dbg_ready       debug write accepted this cycle
//   dbg_rdata       raw array word at dbg_addr (no forwarding)
//   sb_count        occupied store buffer entries
//   sb_empty        sb_count == 0
module dmem_store_buffer_unit #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MemWrite,
  input  logic [0:31]                 dmem_addr,
  input  logic [0:1]                  byte_select,
  input  logic [0:31]                 dmem_din,
  output logic [0:31]                 dmem_dout,
  input  logic                        dbg_req,
  input  logic [0:ADDR_W-1]           dbg_addr,
  input  logic [0:31]                 dbg_wdata,
  output logic                        dbg_ready,
  output logic [0:31]                 dbg_rdata,
  output logic [0:$clog2(SB_DEPTH)]   sb_count,
  output logic                        sb_empty
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(SB_DEPTH);

  // Word array (not reset) and store buffer payload.
  logic [0:31]       mem_q     [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] sb_addr_q [0:SB_DEPTH-1];
  logic [0:3]        sb_mask_q [0:SB_DEPTH-1];
  logic [0:31]       sb_data_q [0:SB_DEPTH-1];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        offs;
  logic [0:3]        st_mask;
  logic [0:31]       st_data;
  logic [0:31]       fwd_word;
  logic [PW-1:0]     fwd_idx;
  logic              full;
  logic              drain;
  logic              unused_addr_hi;

  assign word_idx       = dmem_addr[30-ADDR_W:29];
  assign offs           = dmem_addr[30:31];
  assign unused_addr_hi = ^dmem_addr[0:29-ADDR_W];

  // Lane mask and lane-replicated data for an incoming store.
  always_comb begin
    st_mask = '0;
    st_data = dmem_din;
    case (byte_select)
      2'b00: begin
        st_mask[offs] = 1'b1;
        st_data       = {4{dmem_din[24:31]}};
      end
      2'b01: begin
        st_mask = offs[1] ? 4'b0011 : 4'b1100;
        st_data = {2{dmem_din[16:31]}};
      end
      default: st_mask = '1;
    endcase
  end

  // Overlay buffered stores oldest-first so the youngest wins each lane.
  always_comb begin
    fwd_word = mem_q[word_idx];
    fwd_idx  = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (sb_addr_q[fwd_idx] == word_idx)) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (sb_mask_q[fwd_idx][k]) begin
            fwd_word[8*k +: 8] = sb_data_q[fwd_idx][8*k +: 8];
          end
        end
      end
    end
  end

  // Left-align the addressed field.
  always_comb begin
    dmem_dout = '0;
    case (byte_select)
      2'b00:   dmem_dout[0:7]  = fwd_word[{offs, 3'b000} +: 8];
      2'b01:   dmem_dout[0:15] = offs[1] ? fwd_word[16:31] : fwd_word[0:15];
      default: dmem_dout       = fwd_word;
    endcase
  end

  // A full buffer facing a new store must drain, so the debug port yields.
  assign full      = (count_q == FULL_CNT);
  assign dbg_ready = dbg_req & ~(full & MemWrite);
  assign drain     = (count_q != '0) & ~dbg_ready;

  always_comb begin
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(MemWrite);
    count_d = count_q;
    case ({MemWrite, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: an entry is only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (MemWrite) begin
      sb_addr_q[tail_q] <= word_idx;
      sb_mask_q[tail_q] <= st_mask;
      sb_data_q[tail_q] <= st_data;
    end
  end

  // Single array write port: debug grant, otherwise head drain.
  always_ff @(posedge clk) begin
    if (dbg_ready) begin
      mem_q[dbg_addr] <= dbg_wdata;
    end else if (drain) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (sb_mask_q[head_q][k]) begin
          mem_q[sb_addr_q[head_q]][8*k +: 8] <= sb_data_q[head_q][8*k +: 8];
        end
      end
    end
  end

  assign dbg_rdata = mem_q[dbg_addr];
  assign sb_count  = count_q;
  assign sb_empty  = (count_q == '0);

endmodule
